// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Two-requester single-port RAM arbiter, round-robin with bounded lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
    parameter int SIZE     = 14,
    parameter int MAX_LOCK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic            wr0,
    input  logic            wr1,
    input  logic [SIZE-1:0] addr0,
    input  logic [SIZE-1:0] addr1,
    input  logic [31:0]     wdata0,
    input  logic [31:0]     wdata1,
    input  logic            lock0,
    input  logic            lock1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [31:0]     rdata,
    output logic            wrEn,
    output logic [SIZE-1:0] addr_toRAM,
    output logic [31:0]     data_toRAM,
    input  logic [31:0]     data_fromRAM
);

    localparam int                 c_CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_LOCK);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_last;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_lock;
    logic               w_under_limit;

    assign w_under_limit = (r_cnt < c_MAX);

    // Grants are forced low during reset so the RAM sees no access.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && !req1) begin
                w_gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                w_gnt1 = 1'b1;
            end else if (req0 && req1) begin
                case (r_state)
                    c_OWN0: begin
                        w_gnt0 = w_under_limit;
                        w_gnt1 = !w_under_limit;
                    end
                    c_OWN1: begin
                        w_gnt1 = w_under_limit;
                        w_gnt0 = !w_under_limit;
                    end
                    default: begin
                        w_gnt0 = r_last;
                        w_gnt1 = !r_last;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_lock      = (w_gnt0 & lock0) | (w_gnt1 & lock1);
        w_state_nxt = c_IDLE;
        if (w_lock) begin
            w_state_nxt = w_gnt1 ? c_OWN1 : c_OWN0;
        end
        // Count only a contested, locked re-grant to the previous winner.
        w_cnt_nxt = '0;
        if (w_lock && req0 && req1 && (w_gnt1 == r_last)) begin
            w_cnt_nxt = (r_cnt == c_MAX) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end
            r_rvalid0 <= w_gnt0 & ~wr0;
            r_rvalid1 <= w_gnt1 & ~wr1;
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    // Masking with rst drops a read that was in flight when reset arrived.
    assign rvalid0    = r_rvalid0 & ~rst;
    assign rvalid1    = r_rvalid1 & ~rst;
    assign rdata      = data_fromRAM;
    assign wrEn       = (w_gnt0 & wr0) | (w_gnt1 & wr1);
    assign addr_toRAM = w_gnt0 ? addr0 : (w_gnt1 ? addr1 : '0);
    assign data_toRAM = (w_gnt0 && wr0) ? wdata0 :
                        ((w_gnt1 && wr1) ? wdata1 : 32'd0);

endmodule

`default_nettype wire
